// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Load/store unit between execute and a word-wide req/ack data
//            memory port. Handles byte lanes, load extension, a per-beat
//            ack watchdog and, with MISALIGN_SPLIT_EN defined, splitting of
//            misaligned accesses into two word beats.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned MEM_AW      = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BEAT1 = 2'd1;
    localparam logic [1:0] c_BEAT2 = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int unsigned      c_CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_CW-1:0]  c_TMO_LAST = c_CW'(TIMEOUT_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              w_set_err;
    logic              r_err;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [1:0]        r_off;
    logic [MEM_AW-1:0] r_waddr;
    logic [3:0]        r_be1;
    logic [31:0]       r_wdata_rot;
    logic [c_CW-1:0]   r_cnt;
    logic              w_tmo;
`ifdef MISALIGN_SPLIT_EN
    logic              r_split;
    logic [3:0]        r_be2;
    logic [31:0]       r_stage;
`endif

    logic [3:0]  w_nmask;
    logic [7:0]  w_lane8;
    logic        w_in_split;
    logic        w_in_illegal;
    logic [31:0] w_wrot;

    // Lane mask spans two words; the upper nibble is the second beat.
    always_comb begin
        w_nmask = 4'b0000;
        case (size)
            2'b00:   w_nmask = 4'b0001;
            2'b01:   w_nmask = 4'b0011;
            2'b10:   w_nmask = 4'b1111;
            default: w_nmask = 4'b0000;
        endcase
    end

    assign w_lane8      = {4'b0000, w_nmask} << addr[1:0];
    assign w_in_split   = |w_lane8[7:4];
    assign w_in_illegal = (size == 2'b11);

    always_comb begin
        w_wrot = wdata;
        case (addr[1:0])
            2'd1:    w_wrot = {wdata[23:0], wdata[31:24]};
            2'd2:    w_wrot = {wdata[15:0], wdata[31:16]};
            2'd3:    w_wrot = {wdata[7:0],  wdata[31:8]};
            default: w_wrot = wdata;
        endcase
    end

    // dw holds {beat2 word, beat1 word}; shifting by the offset aligns byte 0.
    function automatic logic [31:0] f_extend(input logic [63:0] dw, input logic [1:0] off,
                                             input logic [1:0] sz, input logic u);
        logic [31:0] v;
        v = 32'(dw >> {off, 3'b000});
        case (sz)
            2'b00:   f_extend = {{24{~u & v[7]}}, v[7:0]};
            2'b01:   f_extend = {{16{~u & v[15]}}, v[15:0]};
            default: f_extend = v;
        endcase
    endfunction

    assign w_tmo = (TIMEOUT_CYC != 0) && (r_cnt == c_TMO_LAST);

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req) begin
                    if (w_in_illegal) begin
                        w_next    = c_DONE;
                        w_set_err = 1'b1;
                    end
`ifndef MISALIGN_SPLIT_EN
                    else if (w_in_split) begin
                        w_next    = c_DONE;
                        w_set_err = 1'b1;
                    end
`endif
                    else begin
                        w_next = c_BEAT1;
                    end
                end
            end
            c_BEAT1: begin
                if (mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
                    w_next = r_split ? c_BEAT2 : c_DONE;
`else
                    w_next = c_DONE;
`endif
                end else if (w_tmo) begin
                    w_next    = c_DONE;
                    w_set_err = 1'b1;
                end
            end
`ifdef MISALIGN_SPLIT_EN
            c_BEAT2: begin
                if (mem_ack) begin
                    w_next = c_DONE;
                end else if (w_tmo) begin
                    w_next    = c_DONE;
                    w_set_err = 1'b1;
                end
            end
`endif
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign err       = done & r_err;
    assign mem_req   = (r_state == c_BEAT1) || (r_state == c_BEAT2);
    assign mem_we    = mem_req & r_we;
    assign mem_wdata = mem_req ? r_wdata_rot : 32'd0;

    always_comb begin
        mem_addr = '0;
        mem_be   = 4'b0000;
        if (r_state == c_BEAT1) begin
            mem_addr = r_waddr;
            mem_be   = r_be1;
        end
`ifdef MISALIGN_SPLIT_EN
        else if (r_state == c_BEAT2) begin
            mem_addr = r_waddr + MEM_AW'(1);
            mem_be   = r_be2;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_off       <= 2'b00;
            r_waddr     <= '0;
            r_be1       <= 4'b0000;
            r_wdata_rot <= 32'd0;
            r_cnt       <= '0;
            rdata       <= 32'd0;
`ifdef MISALIGN_SPLIT_EN
            r_split     <= 1'b0;
            r_be2       <= 4'b0000;
            r_stage     <= 32'd0;
`endif
        end else begin
            r_state <= w_next;
            r_err   <= w_set_err;
            if (r_state == c_IDLE && req) begin
                r_we        <= we;
                r_size      <= size;
                r_uns       <= uns;
                r_off       <= addr[1:0];
                r_waddr     <= addr[MEM_AW+1:2];
                r_be1       <= w_lane8[3:0];
                r_wdata_rot <= w_wrot;
`ifdef MISALIGN_SPLIT_EN
                r_split     <= w_in_split;
                r_be2       <= w_lane8[7:4];
`endif
            end
            // Watchdog restarts on every ack so each beat gets a full budget.
            if (mem_req && !mem_ack) begin
                r_cnt <= r_cnt + c_CW'(1);
            end else begin
                r_cnt <= '0;
            end
`ifdef MISALIGN_SPLIT_EN
            if (r_state == c_BEAT1 && mem_ack && !r_we) begin
                if (r_split) begin
                    r_stage <= mem_rdata;
                end else begin
                    rdata <= f_extend({32'd0, mem_rdata}, r_off, r_size, r_uns);
                end
            end
            if (r_state == c_BEAT2 && mem_ack && !r_we) begin
                rdata <= f_extend({mem_rdata, r_stage}, r_off, r_size, r_uns);
            end
`else
            if (r_state == c_BEAT1 && mem_ack && !r_we) begin
                rdata <= f_extend({32'd0, mem_rdata}, r_off, r_size, r_uns);
            end
`endif
        end
    end

endmodule
`default_nettype wire
